// File: rtl/fifo_frame_packer.sv
// Drains a first-word-fall-through FIFO into a local buffer and emits framed packets.
// Each packet is SYNC, LEN, payload, CSUM. A partial buffer is flushed after TIMEOUT idle cycles.
module fifo_frame_packer #(
  parameter int          MAX_PAYLOAD = 32,
  parameter int          TIMEOUT     = 255,
  parameter logic [7:0]  SYNC_BYTE   = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_nempty,
  input  logic [7:0]  in_data,
  output logic        in_pop,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_last,
  output logic [15:0] frames_sent
);

  localparam int AW = (MAX_PAYLOAD < 2) ? 1 : $clog2(MAX_PAYLOAD);
  localparam int TW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
  localparam logic [7:0]    MAXP   = 8'(MAX_PAYLOAD);

  localparam logic [2:0] ST_COLLECT = 3'd0;
  localparam logic [2:0] ST_SYNC    = 3'd1;
  localparam logic [2:0] ST_LEN     = 3'd2;
  localparam logic [2:0] ST_PAYLOAD = 3'd3;
  localparam logic [2:0] ST_CSUM    = 3'd4;

  logic [2:0]    state_q, state_d;
  logic [7:0]    count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [7:0]    csum_q, csum_d;
  logic [7:0]    idx_q, idx_d;
  logic          out_valid_q, out_valid_d;
  logic [7:0]    out_data_q, out_data_d;
  logic          out_last_q, out_last_d;
  logic [15:0]   frames_q, frames_d;
  logic [7:0]    buf_q [MAX_PAYLOAD];

  logic [7:0] idx_inc;
  logic       accept;

  assign in_pop  = in_nempty && (state_q == ST_COLLECT) && (count_q < MAXP) && !rst;
  assign idx_inc = idx_q + 8'd1;
  assign accept  = out_valid_q && out_ready;

  assign out_valid   = out_valid_q;
  assign out_data    = out_data_q;
  assign out_last    = out_last_q;
  assign frames_sent = frames_q;

  // Payload storage needs no reset: count_q gates which entries are ever read.
  always_ff @(posedge clk) begin
    if (in_pop) buf_q[count_q[AW-1:0]] <= in_data;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    timer_d     = timer_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    frames_d    = frames_q;
    case (state_q)
      ST_COLLECT: begin
        if (in_pop) begin
          count_d = count_q + 8'd1;
          csum_d  = csum_q + in_data;
          timer_d = '0;
          if (count_q + 8'd1 == MAXP) begin
            state_d     = ST_SYNC;
            out_valid_d = 1'b1;
            out_data_d  = SYNC_BYTE;
            out_last_d  = 1'b0;
          end
        end else if (count_q != 8'd0) begin
          // A pop always wins, so the timeout is only evaluated on idle cycles.
          if (timer_q == T_LAST) begin
            state_d     = ST_SYNC;
            out_valid_d = 1'b1;
            out_data_d  = SYNC_BYTE;
            out_last_d  = 1'b0;
          end else begin
            timer_d = timer_q + 1'b1;
          end
        end
      end
      ST_SYNC: begin
        if (accept) begin
          state_d    = ST_LEN;
          out_data_d = count_q;
        end
      end
      ST_LEN: begin
        if (accept) begin
          state_d    = ST_PAYLOAD;
          idx_d      = 8'd0;
          out_data_d = buf_q[0];
        end
      end
      ST_PAYLOAD: begin
        if (accept) begin
          if (idx_q == count_q - 8'd1) begin
            state_d    = ST_CSUM;
            out_data_d = csum_q + count_q;
            out_last_d = 1'b1;
          end else begin
            idx_d      = idx_inc;
            out_data_d = buf_q[idx_inc[AW-1:0]];
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          state_d     = ST_COLLECT;
          count_d     = 8'd0;
          timer_d     = '0;
          csum_d      = 8'd0;
          idx_d       = 8'd0;
          out_valid_d = 1'b0;
          out_data_d  = 8'd0;
          out_last_d  = 1'b0;
          frames_d    = frames_q + 16'd1;
        end
      end
      default: state_d = ST_COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_COLLECT;
      count_q     <= 8'd0;
      timer_q     <= '0;
      csum_q      <= 8'd0;
      idx_q       <= 8'd0;
      out_valid_q <= 1'b0;
      out_data_q  <= 8'd0;
      out_last_q  <= 1'b0;
      frames_q    <= 16'd0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      timer_q     <= timer_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      frames_q    <= frames_d;
    end
  end

endmodule

// File: tb/tb_fifo_frame_packer.sv
// Directed bench for fifo_frame_packer: a queue models the FWFT FIFO, and a monitor records the accepted beats.
module tb_fifo_frame_packer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_nempty = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_pop;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [7:0]  out_data;
  logic        out_last;
  logic [15:0] frames_sent;

  fifo_frame_packer dut (
    .clk(clk), .rst(rst), .in_nempty(in_nempty), .in_data(in_data), .in_pop(in_pop),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .frames_sent(frames_sent)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  logic [7:0] fifo [$];
  bit         feed_en = 1'b0;
  bit         rand_ready = 1'b0;
  bit         ready_fix = 1'b1;
  bit         pop_pend = 1'b0;

  logic [7:0] cap_d [$];
  bit         cap_l [$];
  int cyc = 0, pop_cnt = 0, vld_cnt = 0, emit_pop = 0, stall_err = 0;
  int last_pop_cyc = 0, first_vld_cyc = -1;
  bit prev_stall = 1'b0, prev_valid = 1'b0, prev_rst = 1'b1;
  logic [7:0] prev_data = 8'h00;
  logic       prev_last = 1'b0;

  // The monitor samples on the falling edge; these are the values the DUT sees at the next rising edge.
  always @(negedge clk) begin
    cyc++;
    pop_pend = in_pop;
    if (in_pop) begin pop_cnt++; last_pop_cyc = cyc; end
    if (out_valid) vld_cnt++;
    if (out_valid && in_pop) emit_pop++;
    if (out_valid && !prev_valid && first_vld_cyc < 0) first_vld_cyc = cyc;
    if (prev_stall && !prev_rst && (!out_valid || out_data !== prev_data || out_last !== prev_last))
      stall_err++;
    if (out_valid && out_ready) begin cap_d.push_back(out_data); cap_l.push_back(out_last); end
    prev_stall = out_valid && !out_ready;
    prev_data  = out_data;
    prev_last  = out_last;
    prev_valid = out_valid;
    prev_rst   = rst;
  end

  // The FIFO head and out_ready update 2 ns after each rising edge.
  always @(posedge clk) begin
    #2;
    if (pop_pend && fifo.size() > 0) void'(fifo.pop_front());
    pop_pend  = 1'b0;
    in_nempty = feed_en && (fifo.size() > 0);
    in_data   = (fifo.size() > 0) ? fifo[0] : 8'h00;
    out_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_fix;
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; feed_en = 1'b0; fifo.delete(); rand_ready = 1'b0; ready_fix = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    cap_d.delete(); cap_l.delete();
    pop_cnt = 0; vld_cnt = 0; emit_pop = 0; stall_err = 0; first_vld_cyc = -1;
  endtask

  task automatic wait_beats(input int n, input int budget, output bit to);
    for (int i = 0; i < budget && cap_d.size() < n; i++) @(posedge clk);
    #1;
    to = (cap_d.size() < n);
  endtask

  task automatic test_reset();
    rst = 1'b1; feed_en = 1'b1; fifo.delete(); fifo.push_back(8'h77);
    tick(); tick(); #3;
    total++; if (in_pop !== 1'b0) begin bad++; $display("FAIL reset_pop got=%b want=0", in_pop); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (out_last !== 1'b0) begin bad++; $display("FAIL reset_last got=%b want=0", out_last); end
    total++; if (out_data !== 8'h00) begin bad++; $display("FAIL reset_data got=%h want=00", out_data); end
    total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL reset_frames got=%0d want=0", frames_sent); end
    do_reset();
  endtask

  task automatic test_idle();
    do_reset();
    repeat (1000) tick();
    total++; if (vld_cnt !== 0) begin bad++; $display("FAIL idle_valid got=%0d want=0", vld_cnt); end
    total++; if (pop_cnt !== 0) begin bad++; $display("FAIL idle_pop got=%0d want=0", pop_cnt); end
    total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL idle_frames got=%0d want=0", frames_sent); end
  endtask

  task automatic test_full_frame();
    logic [7:0] exp [$];
    bit to;
    do_reset();
    for (int i = 0; i < 32; i++) fifo.push_back(8'(i));
    feed_en = 1'b1;
    exp.push_back(8'hA5); exp.push_back(8'h20);
    for (int i = 0; i < 32; i++) exp.push_back(8'(i));
    exp.push_back(8'h10);
    wait_beats(35, 200, to);
    repeat (3) tick();
    total++; if (to) begin bad++; $display("FAIL full_timeout got=%0d beats want=35", cap_d.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (i >= cap_d.size() || cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        bad++; $display("FAIL full_beat%0d got=%h/%b want=%h/%b", i, cap_d[i], cap_l[i], exp[i], i == exp.size() - 1);
      end
    end
    total++; if (cap_d.size() != 35) begin bad++; $display("FAIL full_len got=%0d want=35", cap_d.size()); end
    total++; if (pop_cnt !== 32) begin bad++; $display("FAIL full_pops got=%0d want=32", pop_cnt); end
    total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL full_frames got=%0d want=1", frames_sent); end
  endtask

  task automatic test_timeout();
    logic [7:0] exp [$];
    bit to;
    do_reset();
    fifo.push_back(8'h01); fifo.push_back(8'h02); fifo.push_back(8'h03);
    feed_en = 1'b1;
    exp = '{8'hA5, 8'h03, 8'h01, 8'h02, 8'h03, 8'h09};
    wait_beats(6, 400, to);
    repeat (3) tick();
    total++; if (to) begin bad++; $display("FAIL tmo_timeout got=%0d beats want=6", cap_d.size()); end
    total++;
    if (first_vld_cyc - last_pop_cyc != 256) begin
      bad++; $display("FAIL tmo_latency got=%0d want=256", first_vld_cyc - last_pop_cyc);
    end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (i >= cap_d.size() || cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        bad++; $display("FAIL tmo_beat%0d got=%h/%b want=%h/%b", i, cap_d[i], cap_l[i], exp[i], i == exp.size() - 1);
      end
    end
    total++; if (cap_d.size() != 6) begin bad++; $display("FAIL tmo_len got=%0d want=6", cap_d.size()); end
    total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL tmo_frames got=%0d want=1", frames_sent); end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [$];
    bit to;
    do_reset();
    rand_ready = 1'b1;
    // The extra trailing byte keeps in_nempty high throughout emission.
    for (int i = 0; i < 32; i++) fifo.push_back(8'(i));
    fifo.push_back(8'h55);
    feed_en = 1'b1;
    exp.push_back(8'hA5); exp.push_back(8'h20);
    for (int i = 0; i < 32; i++) exp.push_back(8'(i));
    exp.push_back(8'h10);
    wait_beats(35, 600, to);
    tick();
    total++; if (to) begin bad++; $display("FAIL bp_timeout got=%0d beats want=35", cap_d.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (i >= cap_d.size() || cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        bad++; $display("FAIL bp_beat%0d got=%h/%b want=%h/%b", i, cap_d[i], cap_l[i], exp[i], i == exp.size() - 1);
      end
    end
    total++; if (stall_err !== 0) begin bad++; $display("FAIL bp_stall_stable got=%0d want=0", stall_err); end
    total++; if (emit_pop !== 0) begin bad++; $display("FAIL bp_emit_pop got=%0d want=0", emit_pop); end
    total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL bp_frames got=%0d want=1", frames_sent); end
    do_reset();
  endtask

  task automatic test_overflow();
    logic [7:0] exp [$];
    int lasts [2] = '{34, 45};
    bit to;
    do_reset();
    for (int i = 0; i < 40; i++) fifo.push_back(8'(i));
    feed_en = 1'b1;
    exp.push_back(8'hA5); exp.push_back(8'h20);
    for (int i = 0; i < 32; i++) exp.push_back(8'(i));
    exp.push_back(8'h10);
    // Second frame checksum: 8 + (32+...+39) = 292, which is 0x24 modulo 256.
    exp.push_back(8'hA5); exp.push_back(8'h08);
    for (int i = 32; i < 40; i++) exp.push_back(8'(i));
    exp.push_back(8'h24);
    wait_beats(46, 800, to);
    repeat (3) tick();
    total++; if (to) begin bad++; $display("FAIL ovf_timeout got=%0d beats want=46", cap_d.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (i >= cap_d.size() || cap_d[i] !== exp[i] || cap_l[i] !== (i == lasts[0] || i == lasts[1])) begin
        bad++; $display("FAIL ovf_beat%0d got=%h/%b want=%h/%b", i, cap_d[i], cap_l[i], exp[i], i == lasts[0] || i == lasts[1]);
      end
    end
    total++; if (cap_d.size() != 46) begin bad++; $display("FAIL ovf_len got=%0d want=46", cap_d.size()); end
    total++; if (frames_sent !== 16'd2) begin bad++; $display("FAIL ovf_frames got=%0d want=2", frames_sent); end
  endtask

  task automatic test_reset_midframe();
    logic [7:0] exp [$];
    bit to;
    do_reset();
    for (int i = 0; i < 32; i++) fifo.push_back(8'(i));
    feed_en = 1'b1;
    wait_beats(12, 200, to);
    total++; if (to) begin bad++; $display("FAIL mid_timeout got=%0d beats want=12", cap_d.size()); end
    rst = 1'b1;
    #3;
    total++; if (out_data !== 8'h0A) begin bad++; $display("FAIL mid_presented got=%h want=0a", out_data); end
    tick();
    rst = 1'b0;
    #3;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid got=%b want=0", out_valid); end
    total++; if (frames_sent !== 16'd0) begin bad++; $display("FAIL mid_frames got=%0d want=0", frames_sent); end
    tick();
    cap_d.delete(); cap_l.delete();
    for (int i = 0; i < 32; i++) fifo.push_back(8'(i));
    exp.push_back(8'hA5); exp.push_back(8'h20);
    for (int i = 0; i < 32; i++) exp.push_back(8'(i));
    exp.push_back(8'h10);
    wait_beats(35, 200, to);
    repeat (3) tick();
    total++; if (to) begin bad++; $display("FAIL mid2_timeout got=%0d beats want=35", cap_d.size()); end
    for (int i = 0; i < exp.size(); i++) begin
      total++;
      if (i >= cap_d.size() || cap_d[i] !== exp[i] || cap_l[i] !== (i == exp.size() - 1)) begin
        bad++; $display("FAIL mid2_beat%0d got=%h/%b want=%h/%b", i, cap_d[i], cap_l[i], exp[i], i == exp.size() - 1);
      end
    end
    total++; if (frames_sent !== 16'd1) begin bad++; $display("FAIL mid2_frames got=%0d want=1", frames_sent); end
  endtask

  initial begin
    test_reset();
    test_idle();
    test_full_frame();
    test_timeout();
    test_backpressure();
    test_overflow();
    test_reset_midframe();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
